// File: rtl/uart_ovs_if.sv
// uart_ovs_if: uart_ovs bus (baud_div, ss/data/busy TX side, dout/din serial lines, rec_data/rec_valid/rr FIFO, err_clr and sticky error flags)
interface uart_ovs_if #(parameter int DIV_WIDTH = 16, parameter int DATA_BITS = 8);
  logic [DIV_WIDTH-1:0] baud_div;
  logic ss;
  logic [DATA_BITS-1:0] data;
  logic busy;
  logic dout;
  logic din;
  logic [DATA_BITS-1:0] rec_data;
  logic rec_valid;
  logic rr;
  logic err_clr;
  logic rx_overrun;
  logic rx_frame_err;
  logic rx_parity_err;
  modport master (
    output baud_div, ss, data, din, rr, err_clr,
    input busy, dout, rec_data, rec_valid, rx_overrun, rx_frame_err, rx_parity_err
  );
  modport slave (
    input baud_div, ss, data, din, rr, err_clr,
    output busy, dout, rec_data, rec_valid, rx_overrun, rx_frame_err, rx_parity_err
  );
endinterface

// File: rtl/uart_ovs.sv
// uart_ovs: 16x-oversampled UART with runtime baud divisor, glitch-rejecting RX, optional parity, RX FIFO and sticky errors; ports sclk, reset (sync active-low), bus (uart_ovs_if.slave)
module uart_ovs #(
  parameter int DIV_WIDTH = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY_EN = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS = 1,
  parameter int FIFO_DEPTH = 4
) (
  input logic sclk,
  input logic reset,
  uart_ovs_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK} st_t;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = FIFO_DEPTH[CW-1:0];
  localparam logic [3:0] LAST = 4'(DATA_BITS - 1);
  localparam logic [4:0] STOP_END = 5'(16 * STOP_BITS - 1);
  logic [DIV_WIDTH-1:0] div_cnt;
  logic tick;
  assign tick = div_cnt == '0;
  always_ff @(posedge sclk)
    if (!reset) div_cnt <= '0;
    else div_cnt <= tick ? bus.baud_div : div_cnt - DIV_WIDTH'(1);
  st_t tx_st, tx_nx;
  logic [4:0] tx_tc;
  logic [3:0] tx_bc;
  logic [DATA_BITS-1:0] tx_sh;
  logic tx_par, tx_done;
  assign tx_done = tick && tx_tc == (tx_st == S_STOP ? STOP_END : 5'd15);
  always_comb begin
    tx_nx = tx_st;
    case (tx_st)
      S_IDLE: tx_nx = bus.ss ? S_START : S_IDLE;
      S_START: tx_nx = tx_done ? S_DATA : S_START;
      S_DATA: tx_nx = tx_done && tx_bc == LAST ? (PARITY_EN != 0 ? S_PAR : S_STOP) : S_DATA;
      S_PAR: tx_nx = tx_done ? S_STOP : S_PAR;
      S_STOP: tx_nx = tx_done ? S_IDLE : S_STOP;
      default: tx_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge sclk)
    if (!reset) tx_st <= S_IDLE;
    else tx_st <= tx_nx;
  always_ff @(posedge sclk)
    if (tx_st == S_IDLE) begin
      tx_sh <= bus.data;
      tx_par <= ^bus.data ^ 1'(PARITY_ODD);
      tx_tc <= '0;
      tx_bc <= '0;
    end else if (tick) begin
      tx_tc <= tx_done ? '0 : tx_tc + 5'd1;
      if (tx_done && tx_st == S_DATA) begin
        tx_sh <= tx_sh >> 1;
        tx_bc <= tx_bc + 4'd1;
      end
    end
  assign bus.busy = tx_st != S_IDLE;
  assign bus.dout = tx_st == S_START ? 1'b0 : tx_st == S_DATA ? tx_sh[0] : tx_st == S_PAR ? tx_par : 1'b1;
  logic [1:0] sync;
  logic rxd;
  assign rxd = sync[1];
  always_ff @(posedge sclk)
    if (!reset) sync <= 2'b11;
    else sync <= {sync[0], bus.din};
  st_t rx_st, rx_nx;
  logic [3:0] rx_tc, rx_bc;
  logic [DATA_BITS-1:0] rx_sh;
  logic rx_par, rx_samp, par_bad, push, fe_set, pe_set;
  assign rx_samp = tick && rx_tc == (rx_st == S_START ? 4'd7 : 4'd15);
  assign par_bad = PARITY_EN != 0 && (^rx_sh ^ rx_par) != 1'(PARITY_ODD);
  always_comb begin
    rx_nx = rx_st;
    push = 1'b0;
    fe_set = 1'b0;
    pe_set = 1'b0;
    case (rx_st)
      S_IDLE: rx_nx = rxd ? S_IDLE : S_START;
      S_START: rx_nx = !rx_samp ? S_START : rxd ? S_IDLE : S_DATA;
      S_DATA: rx_nx = rx_samp && rx_bc == LAST ? (PARITY_EN != 0 ? S_PAR : S_STOP) : S_DATA;
      S_PAR: rx_nx = rx_samp ? S_STOP : S_PAR;
      S_STOP:
        if (rx_samp) begin
          rx_nx = rxd ? S_IDLE : S_BRK;
          fe_set = !rxd;
          pe_set = rxd && par_bad;
          push = rxd && !par_bad;
        end
      S_BRK: rx_nx = rxd ? S_IDLE : S_BRK;
      default: rx_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge sclk)
    if (!reset) rx_st <= S_IDLE;
    else rx_st <= rx_nx;
  always_ff @(posedge sclk)
    if (rx_st == S_IDLE) begin
      rx_tc <= '0;
      rx_bc <= '0;
    end else if (tick) begin
      rx_tc <= rx_samp ? '0 : rx_tc + 4'd1;
      if (rx_samp && rx_st == S_DATA) begin
        rx_sh <= {rxd, rx_sh[DATA_BITS-1:1]};
        rx_bc <= rx_bc + 4'd1;
      end
      if (rx_samp && rx_st == S_PAR) rx_par <= rxd;
    end
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic full, pop, wr;
  assign full = cnt == FULL;
  assign pop = bus.rr && bus.rec_valid;
  assign wr = push && (!full || pop);
  always_ff @(posedge sclk)
    if (wr) mem[wp] <= rx_sh;
  always_ff @(posedge sclk)
    if (!reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wr ? wp + AW'(1) : wp;
      rp <= pop ? rp + AW'(1) : rp;
      cnt <= cnt + CW'(wr) - CW'(pop);
    end
  assign bus.rec_data = mem[rp];
  assign bus.rec_valid = cnt != '0;
  always_ff @(posedge sclk)
    if (!reset) begin
      bus.rx_overrun <= 1'b0;
      bus.rx_frame_err <= 1'b0;
      bus.rx_parity_err <= 1'b0;
    end else begin
      bus.rx_overrun <= (bus.rx_overrun & ~bus.err_clr) | (push & full & ~pop);
      bus.rx_frame_err <= (bus.rx_frame_err & ~bus.err_clr) | fe_set;
      bus.rx_parity_err <= (bus.rx_parity_err & ~bus.err_clr) | pe_set;
    end
endmodule
